// File: rtl/visumon_pkg.sv
// visumon_pkg: types and constants shared by the visuMon writer and the display receiver.
package visumon_pkg;

    localparam int unsigned LED_COUNT = 64;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned LED_IDX_W = 6;

    // Bit layout on the link: [18:13] ledNo, [12:9] red, [8:5] green, [4:1] blue, [0] status.
    typedef struct packed {
        logic [LED_IDX_W-1:0] ledNo;
        logic [3:0]           red;
        logic [3:0]           green;
        logic [3:0]           blue;
        logic                 status;
    } debugInfo_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wrState_t;

    // Builds one link word from an LED index, its {R,G,B} colour and its status bit.
    function automatic debugInfo_t pack_word(
        input logic [LED_IDX_W-1:0] led,
        input logic [COLOR_W-1:0]   color,
        input logic                 status
    );
        debugInfo_t w;
        w.ledNo  = led;
        w.red    = color[11:8];
        w.green  = color[7:4];
        w.blue   = color[3:0];
        w.status = status;
        return w;
    endfunction

endpackage

// File: rtl/visumon_strobe_gen.sv
// visumon_strobe_gen: SETUP/STROBE/HOLD sequencing of the active-low chip-select for one word.
// A start pulse in IDLE runs one word: 1 SETUP cycle, i_csLowCycles cycles with o_cs low, then
// 1 HOLD cycle. o_busy covers all three; o_done marks the HOLD cycle.
module visumon_strobe_gen
    import visumon_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [3:0] i_csLowCycles,
    output logic       o_cs,
    output logic       o_busy,
    output logic       o_done
);

    wrState_t   r_state;
    wrState_t   w_stateNext;
    logic [3:0] r_cnt;
    logic [3:0] w_cntNext;
    logic       r_cs;

    // Next-state and strobe-length down-counter.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_stateNext = SETUP;
                end
            end
            SETUP: begin
                w_stateNext = STROBE;
                w_cntNext   = i_csLowCycles;
            end
            STROBE: begin
                // A zero length still yields one low cycle so the display always sees an edge.
                if (r_cnt <= 4'd1) begin
                    w_stateNext = HOLD;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            HOLD: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, counter and a glitch-free registered chip-select (forced high by reset).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_cs    <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_cs    <= (w_stateNext != STROBE);
        end
    end

    assign o_cs   = r_cs;
    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == HOLD);

endmodule

// File: rtl/visumon_writer.sv
// visumon_writer: initiator side of the visuMon debug-LED link.
// Scans 64 LED status bits and sends a word for every LED that changed, was recoloured, or is
// still pending since reset. Holds a per-LED colour table written through a req/ack port.
// Optional build macro VISUMON_WRITER_REFRESH_EN adds a free-running counter that re-marks all
// LEDs dirty every REFRESH_PERIOD cycles.
module visumon_writer
    import visumon_pkg::*;
#(
    parameter int unsigned        CS_LOW_CYCLES  = 2,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR  = 12'h0F0,
    parameter int unsigned        REFRESH_PERIOD = 1 << 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [LED_COUNT-1:0] i_leds,
    input  logic                 i_wrReq,
    input  logic [LED_IDX_W-1:0] i_wrLed,
    input  logic [COLOR_W-1:0]   i_wrColor,
    output logic                 o_wrAck,
    output logic                 o_cs,
    output debugInfo_t           o_debugInfo,
    output logic                 o_busy
);

    if (CS_LOW_CYCLES < 1 || CS_LOW_CYCLES > 15) begin : g_bad_cs_low
        $error("CS_LOW_CYCLES must be in 1..15");
    end
    if (REFRESH_PERIOD < 2) begin : g_bad_refresh
        $error("REFRESH_PERIOD must be at least 2");
    end

    logic [LED_IDX_W-1:0] r_ptr;
    logic [LED_COUNT-1:0] r_dirty;
    logic [LED_COUNT-1:0] w_dirtyNext;
    logic [LED_COUNT-1:0] r_sentStatus;
    logic [COLOR_W-1:0]   r_color [LED_COUNT];
    debugInfo_t           r_debugInfo;
    logic                 r_wrAck;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_launch;
    logic                 w_accept;
    logic                 w_refreshTc;

    // The LED under the pointer needs a word if it is dirty or its status differs from the display.
    assign w_launch = !w_busy && (r_dirty[r_ptr] || (i_leds[r_ptr] != r_sentStatus[r_ptr]));
    // A held request is taken only every other cycle so the ack pulse can be seen and dropped.
    assign w_accept = i_wrReq && !r_wrAck;

    visumon_strobe_gen u_strobe_gen (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (w_launch),
        .i_csLowCycles (4'(CS_LOW_CYCLES)),
        .o_cs          (o_cs),
        .o_busy        (w_busy),
        .o_done        (w_done)
    );

`ifdef VISUMON_WRITER_REFRESH_EN
    localparam int unsigned RefreshW = $clog2(REFRESH_PERIOD);

    logic [RefreshW-1:0] r_refreshCnt;

    assign w_refreshTc = (r_refreshCnt == RefreshW'(REFRESH_PERIOD - 1));

    // Free-running refresh timer; wraps after REFRESH_PERIOD cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_refreshCnt <= '0;
        end else if (w_refreshTc) begin
            r_refreshCnt <= '0;
        end else begin
            r_refreshCnt <= r_refreshCnt + RefreshW'(1);
        end
    end
`else
    assign w_refreshTc = 1'b0;
`endif

    // Dirty bookkeeping: launch clears, colour write sets, refresh sets all; sets win over clear.
    always_comb begin
        w_dirtyNext = r_dirty;
        if (w_launch) begin
            w_dirtyNext[r_ptr] = 1'b0;
        end
        if (w_accept) begin
            w_dirtyNext[i_wrLed] = 1'b1;
        end
        if (w_refreshTc) begin
            w_dirtyNext = '1;
        end
    end

    // Scan pointer, sent-status shadow, dirty flags and the outgoing word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ptr        <= '0;
            r_dirty      <= '1;
            r_sentStatus <= '0;
            r_debugInfo  <= '0;
        end else begin
            r_dirty <= w_dirtyNext;
            // Pointer parks on the served LED during the word and steps past it at HOLD.
            if (w_done || (!w_busy && !w_launch)) begin
                r_ptr <= r_ptr + LED_IDX_W'(1);
            end
            // Word is loaded on entry to SETUP so it is stable a full cycle before o_cs falls.
            if (w_launch) begin
                r_debugInfo          <= pack_word(r_ptr, r_color[r_ptr], i_leds[r_ptr]);
                r_sentStatus[r_ptr]  <= i_leds[r_ptr];
            end
        end
    end

    // Colour table and write acknowledge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                r_color[i] <= DEFAULT_COLOR;
            end
            r_wrAck <= 1'b0;
        end else begin
            r_wrAck <= w_accept;
            if (w_accept) begin
                r_color[i_wrLed] <= i_wrColor;
            end
        end
    end

    assign o_wrAck     = r_wrAck;
    assign o_debugInfo = r_debugInfo;
    assign o_busy      = w_busy;

endmodule

// File: doc/visumon_writer.md
# visumon_writer

Initiator side of the visuMon debug-LED link. Watches 64 status bits from the rest of the design and serialises changed LEDs into `debugInfo_t` words. Each word is qualified by an active-low chip-select strobe that the display block latches on its falling edge. It also holds a per-LED colour table that software or debug logic updates through a simple req/ack port.

## Interface
- `CS_LOW_CYCLES`, default 2: cycles `o_cs` is held low per word; legal range 1..15.
- `DEFAULT_COLOR`, default 12'h0F0: reset colour `{R,G,B}` for every LED.
- `REFRESH_PERIOD`, default 2^20: cycles between forced full refreshes; used only with the refresh macro.
- `i_clk` in 1: single clock.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_leds` in 64: LED status vector, synchronous to `i_clk`; bit n drives LED n.
- `i_wrReq` in 1: colour-write request; level, held until ack.
- `i_wrLed` in 6: target LED for the colour write.
- `i_wrColor` in 12: `{red[3:0], green[3:0], blue[3:0]}`.
- `o_wrAck` out 1: one-cycle pulse when the colour write is accepted.
- `o_cs` out 1: active-low strobe; the display latches `o_debugInfo` on its falling edge.
- `o_debugInfo` out `debugInfo_t`: `{ledNo[5:0], red, green, blue, status}`, i.e. bits [18:13], [12:9], [8:5], [4:1], [0].
- `o_busy` out 1: high whenever a word transaction is in progress.

## Operation
- Reset values:
  - outputs: `o_cs`=1, `o_debugInfo`=0, `o_wrAck`=0, `o_busy`=0.
  - internal: colour table = `DEFAULT_COLOR`, `sentStatus`=0, `dirty`=all ones (the display array has no reset, so all 64 LEDs are sent after reset), scan pointer=0, FSM in IDLE.
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
- IDLE, per cycle:
  - Evaluate LED `p` = scan pointer.
  - If `dirty[p]` or `i_leds[p]` != `sentStatus[p]`: go to SETUP with `idx`=`p`.
  - Otherwise `p`<=`p`+1; wraps 63→0.
  - A quiet sweep takes 64 cycles.
- SETUP:
  - `o_debugInfo` <= {`idx`, `color[idx]`, `i_leds[idx]`}; `o_cs` stays 1.
  - `sentStatus[idx]` <= `i_leds[idx]`; `dirty[idx]` cleared.
  - `p` <= `idx`+1.
- STROBE: `o_cs`=0 for exactly `CS_LOW_CYCLES` cycles, counted by a 4-bit down-counter.
- HOLD: `o_cs`=1 for 1 cycle with `o_debugInfo` unchanged, then IDLE.
- `o_debugInfo` is only updated in SETUP and holds its last value otherwise.
- `o_busy`=1 in SETUP, STROBE and HOLD.
- Colour write:
  - Accepted in any state when `i_wrReq`=1 and `o_wrAck` was 0 in the previous cycle.
  - On accept: `color[i_wrLed]` <= `i_wrColor`, `dirty[i_wrLed]` set, `o_wrAck` pulses the next cycle.
  - A requester deasserts `i_wrReq` in the cycle after it sees `o_wrAck`; back-to-back writes therefore take 2 cycles each.
- Simultaneous set and clear of `dirty` for the same LED (colour write during that LED's SETUP): set wins and the LED is resent on a later visit.
- The colour written in the same cycle as SETUP of that LED is not used for this word; the old colour goes out and the new one follows.
- Status toggling during STROBE/HOLD: the mismatch against `sentStatus` is caught on the next visit.
- Async reset mid-transaction: `o_cs` returns to 1 immediately. The word in flight may be lost; the all-dirty reset state resends everything.

## Timing
- One word = `CS_LOW_CYCLES`+2 cycles (default 4); `o_debugInfo` is stable 1 cycle before the falling edge and ≥1 cycle after the rising edge.
- Change-to-falling-edge latency, from `i_leds[n]` change to `o_cs` fall:
  - best case 2 cycles (pointer already at n, FSM idle);
  - worst case 64 + (`CS_LOW_CYCLES`+2)·63 + 1 cycles when all other LEDs are dirty.
- Colour write to ack: 1 cycle.
- Sweep fairness: the pointer always advances past the served LED, so no LED starves.

## Configuration
- `VISUMON_WRITER_REFRESH_EN` defined:
  - A counter of `clog2(REFRESH_PERIOD)` bits runs freely.
  - On terminal count it sets all 64 `dirty` bits in one cycle and restarts; this is an OR with pending sets.
  - This re-sends the whole LED state periodically, so the display recovers after its own reset or a lost strobe.
- Not defined: no counter exists, and LEDs are sent only after reset, on status change, or on colour write.

## Structure
- Shared package `visumon_pkg`:
  - `debugInfo_t` packed struct with the bit layout above;
  - `LED_COUNT`=64;
  - `COLOR_W`=12;
  - FSM state enum `wrState_t` {IDLE, SETUP, STROBE, HOLD}.
- The display receiver imports the same package.
- Sub-module `visumon_strobe_gen`:
  - inputs: start pulse and `CS_LOW_CYCLES`;
  - outputs: `o_cs`, busy, done;
  - owns the SETUP/STROBE/HOLD sequencing.
- The top level owns the scan pointer, `dirty`/`sentStatus`, the colour table and the write port.

## Test plan
- Reset release, `i_leds`=0:
  - exactly 64 words, `ledNo` 0..63 in order, each with status 0 and colour 12'h0F0;
  - 4 cycles per word, `o_cs` low 2 cycles each;
  - then `o_cs` stays 1.
- After the initial sweep, set `i_leds[37]`=1: one word with `ledNo`=37, status=1, colour 12'h0F0; no other strobes.
- Colour write LED 5 = 12'hA3C with `i_leds[5]`=1:
  - `o_wrAck` pulses after 1 cycle;
  - one word `{5, A, 3, C, 1}` follows.
- Colour write to LED 9 issued in LED 9's SETUP cycle:
  - first word carries the old colour;
  - a second word for LED 9 with the new colour follows within one sweep.
- `i_reset` asserted during STROBE: `o_cs`=1 asynchronously; after release a full 64-word sweep occurs.
- With `VISUMON_WRITER_REFRESH_EN` and `REFRESH_PERIOD`=1000, quiet inputs: a 64-word burst every 1000 cycles. Without the macro: no words after the initial sweep.
